// File: rtl/hydra_sram_pkg.sv
// Shared sizing and type definitions for the SRAM matcher blocks.
package hydra_sram_pkg;

  localparam int unsigned SRAM_NUM   = 32;
  localparam int unsigned SRAM_IDX_W = 5;
  localparam int unsigned AMT_W      = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } match_state_t;

  typedef enum logic {
    FIRST_FIT = 1'b0,
    BEST_FIT  = 1'b1
  } match_mode_t;

endpackage

// File: rtl/port_rd_sram_matcher.sv
// Read-side SRAM matcher: sweeps all shared SRAMs for one output port and selects
// the SRAM to read the next packet from (first-fit or best-fit).
module port_rd_sram_matcher
  import hydra_sram_pkg::*;
#(
  parameter int unsigned PORT_IDX = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  match_mode,
  input  logic [AMT_W-1:0]      match_threshold,
  input  logic                  match_enable,
  output logic [SRAM_IDX_W-1:0] probe_sram,
  input  logic [AMT_W-1:0]      probe_amount,
  input  logic                  probe_accessible,
  output logic [1:0]            match_state,
  output logic                  match_suc,
  output logic [SRAM_IDX_W-1:0] matched_sram,
  input  logic                  match_ack
);

  // Each port starts its sweep at a different SRAM to spread the load.
  localparam logic [SRAM_IDX_W-1:0] RrReset = SRAM_IDX_W'({4'(PORT_IDX), 1'b0});

  match_state_t          state_q, state_d;
  match_mode_t           mode_q, mode_d;
  logic [AMT_W-1:0]      thr_q, thr_d;
  logic [5:0]            n_q, n_d;
  logic [SRAM_IDX_W-1:0] start_q, start_d;
  logic [SRAM_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [AMT_W-1:0]      best_amount_q, best_amount_d;
  logic [SRAM_IDX_W-1:0] best_sram_q, best_sram_d;
  logic [SRAM_IDX_W-1:0] matched_q, matched_d;

  logic                  cand, hit, better;
  logic [SRAM_IDX_W-1:0] cand_sram;

  // Responses lag the probe by one cycle, so the candidate is the previous probe.
  assign cand_sram = start_q + n_q[SRAM_IDX_W-1:0] - SRAM_IDX_W'(1);
  assign cand      = (n_q != 6'd0) && probe_accessible && (probe_amount != '0);
  assign hit       = cand && ((mode_q == FIRST_FIT) || (probe_amount >= thr_q));
  assign better    = cand && (probe_amount > best_amount_q);

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= FIRST_FIT;
      thr_q         <= '0;
      n_q           <= '0;
      start_q       <= RrReset;
      rr_ptr_q      <= RrReset;
      best_amount_q <= '0;
      best_sram_q   <= '0;
      matched_q     <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      thr_q         <= thr_d;
      n_q           <= n_d;
      start_q       <= start_d;
      rr_ptr_q      <= rr_ptr_d;
      best_amount_q <= best_amount_d;
      best_sram_q   <= best_sram_d;
      matched_q     <= matched_d;
    end
  end

  // Next-state: sweep control, best tracking and handshake.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    thr_d         = thr_q;
    n_d           = n_q;
    start_d       = start_q;
    rr_ptr_d      = rr_ptr_q;
    best_amount_d = best_amount_q;
    best_sram_d   = best_sram_q;
    matched_d     = matched_q;
    unique case (state_q)
      IDLE: begin
        if (match_enable) begin
          state_d       = SCAN;
          n_d           = '0;
          start_d       = rr_ptr_q;
          mode_d        = match_mode_t'(match_mode);
          thr_d         = match_threshold;
          best_amount_d = '0;
          best_sram_d   = '0;
        end
      end
      SCAN: begin
        if (!match_enable) begin
          state_d = IDLE;
        end else if (hit) begin
          state_d   = DONE;
          matched_d = cand_sram;
        end else begin
          // Strict compare keeps the earlier SRAM on ties.
          if (better) begin
            best_amount_d = probe_amount;
            best_sram_d   = cand_sram;
          end
          if (n_q == 6'd32) begin
            if (best_amount_d != '0) begin
              state_d   = DONE;
              matched_d = best_sram_d;
            end else begin
              n_d = '0;  // empty sweep: start over from the same SRAM
            end
          end else begin
            n_d = n_q + 6'd1;
          end
        end
      end
      DONE: begin
        if (!match_enable) begin
          state_d = IDLE;
        end else if (match_ack) begin
          state_d  = IDLE;
          rr_ptr_d = matched_q + SRAM_IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: probe address follows the sweep; held on the selection in DONE.
  always_comb begin
    probe_sram = rr_ptr_q;
    unique case (state_q)
      SCAN:    probe_sram = start_q + n_q[SRAM_IDX_W-1:0];
      DONE:    probe_sram = matched_q;
      default: probe_sram = rr_ptr_q;
    endcase
  end

  assign match_state  = state_q;
  assign match_suc    = (state_q == DONE);
  assign matched_sram = matched_q;

endmodule

// File: doc/port_rd_sram_matcher.md
Name: port_rd_sram_matcher

Overview:
- Read-side counterpart of the per-port write SRAM matcher.
- For one output port, sweeps the 32 shared SRAMs and picks the SRAM from which the port's next packet is read, using first-fit or best-fit (most queued packets) policy.
- Sits between the per-SRAM occupancy tables (packet counts per destination port, read-port busy flags) and the port's read engine.
- The read engine consumes the selection through a level handshake.

Parameters:
- SRAM_NUM, 32, number of shared SRAMs (power of two).
- SRAM_IDX_W, 5, log2(SRAM_NUM).
- AMT_W, 9, width of per-port packet count per SRAM.
- PORT_IDX, 0, this port's index (0..15); seeds the round-robin pointer.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- match_mode  in  1  0 = first-fit, 1 = best-fit.
- match_threshold  in  AMT_W  best-fit early-exit level.
- match_enable  in  1  level request for a new selection.
- probe_sram  out  SRAM_IDX_W  SRAM whose occupancy is requested this cycle.
- probe_amount  in  AMT_W  packets for this port in the SRAM probed the previous cycle.
- probe_accessible  in  1  read port of the SRAM probed the previous cycle is free.
- match_state  out  2  0 = IDLE, 1 = SCAN, 2 = DONE (3 unused).
- match_suc  out  1  high while in DONE.
- matched_sram  out  SRAM_IDX_W  selected SRAM; valid while match_suc = 1.
- match_ack  in  1  read engine accepts matched_sram.

Behaviour:
- Reset values:
  - state IDLE; match_suc 0; matched_sram 0.
  - rr_ptr = {PORT_IDX[3:0], 1'b0}; probe_sram = rr_ptr.
  - best_amount 0; best_sram 0; probe count n 0.
- IDLE:
  - probe_sram = rr_ptr.
  - match_enable = 1 at an edge -> SCAN with n = 0 and start = rr_ptr.
- SCAN cycle n (n = 0..32):
  - For n < 32, probe_sram = start + n (mod 32).
  - For n >= 1, the inputs sampled belong to SRAM start + n - 1.
  - Candidate = probe_accessible && probe_amount != 0.
- First-fit: the first candidate -> DONE next cycle, matched_sram = that SRAM. The in-flight probe is discarded.
- Best-fit:
  - A candidate with amount > best_amount replaces best_amount and best_sram. Ties keep the earlier SRAM in sweep order.
  - Candidate amount >= match_threshold -> immediate DONE with that SRAM.
  - At n = 32:
    - best_amount > 0 -> DONE with best_sram.
    - Otherwise clear best, n = 0, and re-sweep from the same start.
  - match_threshold = 0 behaves identically to first-fit.
- Latency:
  - Earliest match_suc is 2 cycles after entering SCAN (candidate at n = 1).
  - Worst case for one sweep is 33 cycles plus 1.
  - An empty sweep repeats with a 33-cycle period.
- DONE:
  - match_suc = 1; matched_sram and probe_sram held stable.
  - match_ack = 1 -> rr_ptr <= matched_sram + 1 (wraps 31 -> 0), then IDLE. match_suc is 0 in the following cycle.
- match_enable deasserted:
  - In SCAN or in DONE (without ack) -> IDLE next cycle.
  - rr_ptr is unchanged and the response pending at that point is ignored.
  - match_ack and match_enable both low in DONE -> IDLE, and ack is ignored.
- match_ack outside DONE is ignored.
- match_mode and match_threshold are sampled on entry to SCAN and held for the sweep.
- Reset asserted mid-SCAN or mid-DONE returns to reset values at the next edge; no selection is reported.
- Index arithmetic is modulo SRAM_NUM. All comparisons are unsigned at AMT_W bits.

Decomposition:
- Shared package hydra_sram_pkg holds:
  - SRAM_NUM, SRAM_IDX_W, AMT_W.
  - match_state_t enum: IDLE = 0, SCAN = 1, DONE = 2.
  - match_mode_t: FIRST_FIT = 0, BEST_FIT = 1.
- No sub-module is needed. Best-tracking stays inline as a compare/replace register pair, and the responder model for occupancy tables lives only in the bench.

Test Plan:
1. First-fit: PORT_IDX = 8 (rr_ptr = 16); only SRAM 20 has amount 3 and accessible -> match_suc 6 cycles after SCAN entry, matched_sram = 20; ack -> rr_ptr = 21.
2. Best-fit, threshold 15: SRAM 3 has 4, SRAM 9 has 7, SRAM 30 has 7, start = 0 -> DONE at n = 32 with matched_sram = 9 (tie keeps earlier).
3. Best-fit early exit, threshold 5: start = 0, SRAM 2 has 6 -> DONE with 2 at cycle n = 3 + 1, no full sweep.
4. Wrap and inaccessible: start = 30; SRAM 31 has 5 but accessible = 0; SRAM 1 has 2 -> matched_sram = 1; ack with 31 selected in a rerun -> rr_ptr = 0.
5. Empty: all amounts 0 for 70 cycles -> state stays SCAN, probe_sram repeats start..start+31 with period 33, match_suc never 1; then SRAM 5 gets 1 -> selected.
6. Abort and reset: drop match_enable at SCAN n = 10 -> IDLE, rr_ptr unchanged; assert rst while in DONE -> match_suc = 0, rr_ptr = {PORT_IDX, 0} next cycle.
